// File: rtl/s3g_pkg.sv
// Shared constants, state encoding and the CRC-8 (Maxim/Dallas) step function
// for the S3G multi-channel receiver.
package s3g_pkg;
    localparam logic [7:0] S3G_SYNC    = 8'hD5;
    localparam logic [1:0] ERR_CRC     = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_DATA, ST_CRC} s3g_state_t;

    // Reflected polynomial 0x8C, LSB of the data byte shifted in first.
    function automatic logic [7:0] crc8(input logic [7:0] data, input logic [7:0] crc);
        logic [7:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 8'h8C;
            else                c = c >> 1;
        end
        return c;
    endfunction
endpackage

// File: rtl/s3g_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module s3g_rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          gnt_valid,
    output logic [PW-1:0] gnt_idx
);
    // Scan from the far end so the nearest requester is the last one assigned.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PW'((int'(ptr) + i) % N);
            end
        end
    end
endmodule

// File: rtl/s3g_rx_mc.sv
// Multi-channel S3G packet receiver: locks onto one channel after a sync byte,
// then collects length, payload and CRC-8 into a readable RAM and a shadow bus.
module s3g_rx_mc
    import s3g_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int MAX_LEN = 32,
    parameter int NSHADOW = 16,
    parameter int TIMEOUT = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NCH*8-1:0]                     rx_data,
    input  logic [NCH-1:0]                       rx_done,
    output logic                                 packet_done,
    output logic                                 packet_error,
    output logic [1:0]                           error_code,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] src_ch,
    output logic [7:0]                           payload_len,
    output logic                                 buffer_valid,
    input  logic [7:0]                           buffer_addr,
    output logic [7:0]                           buffer_data,
    output logic [NSHADOW*8-1:0]                 buf_flat
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    s3g_state_t           r_state, w_nxt;
    logic [CHW-1:0]       r_src, r_rr, w_gnt_idx, w_rr_nxt;
    logic [NCH-1:0]       w_req;
    logic                 w_gnt_valid;
    logic [7:0]           r_cnt, r_wr_addr, r_crc, r_len, r_bdata;
    logic [31:0]          r_to_cnt;
    logic                 r_done, r_err, r_bvalid;
    logic [1:0]           r_err_code, w_code;
    logic [NSHADOW*8-1:0] r_flat;
    logic [7:0]           w_byte;
    logic                 w_stb, w_to, w_done, w_err;
    logic [7:0]           r_mem [MAX_LEN];

    always_comb begin
        w_req = '0;
        for (int c = 0; c < NCH; c++)
            w_req[c] = rx_done[c] && (rx_data[8*c +: 8] == S3G_SYNC);
    end

    s3g_rr_arbiter #(.N(NCH), .PW(CHW)) u_arb (
        .req       (w_req),
        .ptr       (r_rr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    assign w_rr_nxt = (int'(w_gnt_idx) + 1 >= NCH) ? '0 : w_gnt_idx + CHW'(1);
    assign w_byte   = rx_data[8*r_src +: 8];
    assign w_stb    = rx_done[r_src];
    assign w_to     = (TIMEOUT > 0) && (r_to_cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_nxt;
    end

    // A strobe always beats the timeout in the same cycle.
    always_comb begin
        w_nxt  = r_state;
        w_done = 1'b0;
        w_err  = 1'b0;
        w_code = '0;
        unique case (r_state)
            ST_IDLE: if (w_gnt_valid) w_nxt = ST_LEN;
            ST_LEN: begin
                if (w_stb) begin
                    if (w_byte > 8'(MAX_LEN)) begin
                        w_err = 1'b1; w_code = ERR_LEN; w_nxt = ST_IDLE;
                    end else if (w_byte == 8'd0) w_nxt = ST_CRC;
                    else                         w_nxt = ST_DATA;
                end else if (w_to) begin
                    w_err = 1'b1; w_code = ERR_TIMEOUT; w_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_stb) begin
                    if (r_cnt == 8'd1) w_nxt = ST_CRC;
                end else if (w_to) begin
                    w_err = 1'b1; w_code = ERR_TIMEOUT; w_nxt = ST_IDLE;
                end
            end
            ST_CRC: begin
                if (w_stb) begin
                    w_nxt = ST_IDLE;
                    if (w_byte == r_crc) w_done = 1'b1;
                    else begin w_err = 1'b1; w_code = ERR_CRC; end
                end else if (w_to) begin
                    w_err = 1'b1; w_code = ERR_TIMEOUT; w_nxt = ST_IDLE;
                end
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src      <= '0;
            r_rr       <= '0;
            r_cnt      <= '0;
            r_wr_addr  <= '0;
            r_crc      <= '0;
            r_len      <= '0;
            r_bdata    <= '0;
            r_to_cnt   <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_bvalid   <= 1'b0;
            r_err_code <= '0;
            r_flat     <= '0;
        end else begin
            r_done   <= w_done;
            r_err    <= w_err;
            if (w_err) r_err_code <= w_code;
            r_to_cnt <= (r_state == ST_IDLE || w_stb) ? 32'd0 : r_to_cnt + 32'd1;
            r_bdata  <= (buffer_addr < 8'(MAX_LEN)) ? r_mem[buffer_addr[AW-1:0]] : 8'd0;
            unique case (r_state)
                ST_IDLE: if (w_gnt_valid) begin
                    r_src <= w_gnt_idx;
                    r_rr  <= w_rr_nxt;
                end
                ST_LEN: if (w_stb) begin
                    r_len     <= w_byte;
                    r_bvalid  <= 1'b0;
                    r_flat    <= '0;
                    r_crc     <= '0;
                    r_wr_addr <= '0;
                    r_cnt     <= w_byte;
                end
                ST_DATA: if (w_stb) begin
                    r_crc     <= crc8(w_byte, r_crc);
                    r_wr_addr <= r_wr_addr + 8'd1;
                    r_cnt     <= r_cnt - 8'd1;
                    for (int i = 0; i < NSHADOW; i++)
                        if (r_wr_addr == 8'(i)) r_flat[8*i +: 8] <= w_byte;
                end
                ST_CRC: if (w_done) r_bvalid <= 1'b1;
                default: ;
            endcase
        end
    end

    // Payload RAM is not reset so it can map onto plain memory.
    always_ff @(posedge clk) begin
        if (r_state == ST_DATA && w_stb) r_mem[r_wr_addr[AW-1:0]] <= w_byte;
    end

    assign packet_done  = r_done;
    assign packet_error = r_err;
    assign error_code   = r_err_code;
    assign src_ch       = r_src;
    assign payload_len  = r_len;
    assign buffer_valid = r_bvalid;
    assign buffer_data  = r_bdata;
    assign buf_flat     = r_flat;
endmodule

// File: tb/tb_s3g_rx_mc.sv
// Scoreboard bench for s3g_rx_mc: expected packet outcomes are queued as bytes
// are driven and compared whenever the receiver pulses done or error.
module tb_s3g_rx_mc;
    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  rx_data;
    logic [1:0]   rx_done;
    logic         packet_done, packet_error, buffer_valid;
    logic [1:0]   error_code;
    logic [0:0]   src_ch;
    logic [7:0]   payload_len, buffer_addr, buffer_data;
    logic [127:0] buf_flat;

    s3g_rx_mc #(.NCH(2), .MAX_LEN(32), .NSHADOW(16), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .packet_done(packet_done), .packet_error(packet_error), .error_code(error_code),
        .src_ch(src_ch), .payload_len(payload_len), .buffer_valid(buffer_valid),
        .buffer_addr(buffer_addr), .buffer_data(buffer_data), .buf_flat(buf_flat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       done;
        logic [1:0] code;
        logic       src;
        logic [7:0] len;
        logic [7:0] b0;
        logic       to;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_err = 0;
    int   cyc = 0, last_stb = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] m_crc(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            logic fb;
            fb = r[0] ^ d[i];
            r  = {1'b0, r[7:1]};
            if (fb) r = r ^ 8'h8C;
        end
        return r;
    endfunction

    task automatic push(input logic done, input logic [1:0] code, input logic src,
                        input logic [7:0] len, input logic [7:0] b0, input logic to);
        exp_t e;
        e.done = done; e.code = code; e.src = src; e.len = len; e.b0 = b0; e.to = to;
        q.push_back(e);
    endtask

    task automatic send_raw(input logic [1:0] en, input logic [7:0] d0, input logic [7:0] d1);
        rx_data = {d1, d0};
        rx_done = en;
        @(posedge clk); #1;
        last_stb = cyc;
        rx_done = 2'b00;
    endtask

    task automatic send(input int ch, input logic [7:0] b);
        if (ch == 0) send_raw(2'b01, b, 8'h00);
        else         send_raw(2'b10, 8'h00, b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst && (packet_done || packet_error)) begin
            chk("pulse_excl", 32'(packet_done & packet_error), 0);
            if (q.size() == 0) chk("unexpected_pulse", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("kind", 32'(packet_done), 32'(e.done));
                if (!e.done) chk("error_code", 32'(error_code), 32'(e.code));
                chk("src_ch", 32'(src_ch), 32'(e.src));
                chk("payload_len", 32'(payload_len), 32'(e.len));
                chk("buffer_valid", 32'(buffer_valid), 32'(e.done));
                if (e.done) chk("buf_flat0", 32'(buf_flat[7:0]), 32'(e.b0));
                chk("latency", 32'(cyc - last_stb), e.to ? 32'd100 : 32'd0);
            end
        end
    end

    initial begin
        logic [7:0] c;
        rst = 1'b0; rx_data = '0; rx_done = '0; buffer_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", 32'(packet_done), 0);
        chk("rst_err", 32'(packet_error), 0);
        chk("rst_code", 32'(error_code), 0);
        chk("rst_src", 32'(src_ch), 0);
        chk("rst_len", 32'(payload_len), 0);
        chk("rst_bvalid", 32'(buffer_valid), 0);
        chk("rst_bdata", 32'(buffer_data), 0);
        chk("rst_flat", 32'(buf_flat != '0), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // good one-byte packet on ch0, then read it back through the RAM port
        push(1, 0, 0, 8'h01, 8'h01, 0);
        send(0, 8'hD5); send(0, 8'h01); send(0, 8'h01); send(0, 8'h5E);
        drain();
        buffer_addr = 8'd0;
        @(posedge clk); @(negedge clk);
        chk("ram_rd0", 32'(buffer_data), 32'h01);

        // bad CRC
        push(0, 2'd1, 0, 8'h01, 8'h00, 0);
        send(0, 8'hD5); send(0, 8'h01); send(0, 8'h01); send(0, 8'h5F);
        drain();
        chk("bvalid_after_crc_err", 32'(buffer_valid), 0);

        // oversize length, then zero-length packet
        push(0, 2'd2, 0, 8'h21, 8'h00, 0);
        send(0, 8'hD5); send(0, 8'h21);
        drain();
        push(1, 0, 0, 8'h00, 8'h00, 0);
        send(0, 8'hD5); send(0, 8'h00); send(0, 8'h00);
        drain();

        // plain timeout 100 cycles after the last strobe
        push(0, 2'd3, 0, 8'h03, 8'h00, 1);
        send(0, 8'hD5); send(0, 8'h03); send(0, 8'hAA);
        drain();
        chk("code_holds", 32'(error_code), 3);
        // strobe on cycle 99 restarts the count
        push(0, 2'd3, 0, 8'h03, 8'h00, 1);
        send(0, 8'hD5); send(0, 8'h03); send(0, 8'hAA);
        idle(98);
        send(0, 8'hBB);
        drain();
        // strobe on the timeout cycle itself wins
        c = m_crc(m_crc(8'h00, 8'hAA), 8'hBB);
        push(1, 0, 0, 8'h02, 8'hAA, 0);
        send(0, 8'hD5); send(0, 8'h02); send(0, 8'hAA);
        idle(99);
        send(0, 8'hBB); send(0, c);
        drain();

        // async reset in the middle of DATA: no pulse, everything zero
        send(0, 8'hD5); send(0, 8'h02); send(0, 8'h11);
        buffer_addr = 8'd0;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("arst_code", 32'(error_code), 0);
        chk("arst_len", 32'(payload_len), 0);
        chk("arst_bdata", 32'(buffer_data), 0);
        chk("arst_flat", 32'(buf_flat != '0), 0);
        chk("arst_pulses", 32'(packet_done | packet_error), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);

        // simultaneous sync on both channels: ch0 first, ch1 noise ignored
        c = m_crc(m_crc(8'h00, 8'hAA), 8'hD5);
        push(1, 0, 0, 8'h02, 8'hAA, 0);
        send_raw(2'b11, 8'hD5, 8'hD5);
        send_raw(2'b11, 8'h02, 8'h05);
        send(1, 8'h07);
        send_raw(2'b11, 8'hAA, 8'hD5);
        send_raw(2'b11, 8'hD5, 8'h01);
        send_raw(2'b11, c, 8'h00);
        drain();
        buffer_addr = 8'd1;
        @(posedge clk); @(negedge clk);
        chk("ram_rd1", 32'(buffer_data), 32'hD5);

        // second simultaneous sync goes to ch1
        c = m_crc(8'h00, 8'h33);
        push(1, 0, 1, 8'h01, 8'h33, 0);
        @(posedge clk); #1;
        send_raw(2'b11, 8'hD5, 8'hD5);
        send_raw(2'b11, 8'h09, 8'h01);
        send_raw(2'b11, 8'hD5, 8'h33);
        send_raw(2'b11, 8'h00, c);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
